// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-wide data_mem.
// Byte/halfword stores are done as a read-modify-write over IDLE -> MERGE.

module lsu_byte_merge (
  input  logic       en,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] out_byte
);
  assign out_byte = en ? new_byte : old_byte;
endmodule

module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic [31:0]           load_data,
  output logic                  stall,
  output logic                  addr_err,
  output logic [ADDR_WIDTH-1:0] bad_addr,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] MERGE = 1'b1;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic [0:0]            state;
  logic [31:0]           merge_reg;
  logic [ADDR_WIDTH-1:0] hold_addr;

  logic                  fault;
  logic                  req_live;
  logic [NUM_LANES-1:0]  lane_en;
  logic [NUM_LANES-1:0][VEC_W-1:0] old_lanes, new_lanes, merged;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [31:0]           ext_data;
  logic [ADDR_WIDTH-1:0] aligned_addr;

  // Requests are only decoded in IDLE; during MERGE the held request is replayed.
  assign req_live = req_valid && (state == IDLE);

  always_comb begin
    fault = 1'b0;
    case (req_size)
      SZ_H:    fault = req_addr[0];
      SZ_W:    fault = (req_addr[1:0] != 2'b00);
      SZ_B:    fault = 1'b0;
      default: fault = 1'b1;
    endcase
  end

  assign aligned_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    lane_en = '0;
    if (req_size == SZ_B) lane_en[req_addr[1:0]] = 1'b1;
    else                  lane_en = req_addr[1] ? 4'b1100 : 4'b0011;
  end

  assign old_lanes = mem_read_data;
  assign new_lanes = (req_size == SZ_B) ? {4{req_wdata[7:0]}} : {2{req_wdata[15:0]}};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      lsu_byte_merge u_merge (
        .en       (lane_en[g]),
        .old_byte (old_lanes[g]),
        .new_byte (new_lanes[g]),
        .out_byte (merged[g])
      );
    end
  endgenerate

  assign sel_byte = old_lanes[req_addr[1:0]];
  assign sel_half = req_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];

  always_comb begin
    case (req_size)
      SZ_B:    ext_data = {{24{sel_byte[7] & ~req_unsigned}}, sel_byte};
      SZ_H:    ext_data = {{16{sel_half[15] & ~req_unsigned}}, sel_half};
      default: ext_data = mem_read_data;
    endcase
  end

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    stall          = 1'b0;
    load_data      = '0;
    mem_write_data = '0;
    mem_address    = aligned_addr;
    if (state == MERGE) begin
      mem_write      = 1'b1;
      mem_write_data = merge_reg;
      mem_address    = hold_addr;
    end else if (req_valid && !fault) begin
      if (!req_write) begin
        mem_read  = 1'b1;
        load_data = ext_data;
      end else if (req_size == SZ_W) begin
        mem_write      = 1'b1;
        mem_write_data = req_wdata;
      end else begin
        mem_read = 1'b1;
        stall    = 1'b1;
      end
    end
    // Reset must block any in-flight write, including the MERGE write.
    if (!rst_n) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      stall     = 1'b0;
      load_data = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      merge_reg <= '0;
      hold_addr <= '0;
      addr_err  <= 1'b0;
      bad_addr  <= '0;
    end else begin
      addr_err <= req_live && fault;
      if (req_live && fault) bad_addr <= req_addr;
      case (state)
        IDLE: if (req_valid && !fault && req_write && req_size != SZ_W) begin
          state     <= MERGE;
          merge_reg <= merged;
          hold_addr <= aligned_addr;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a word-array data_mem model.

module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [31:0] load_data, bad_addr, mem_address, mem_write_data, mem_read_data;
  logic        stall, addr_err, mem_read, mem_write;

  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:15];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  logic        seen_write;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .load_data(load_data), .stall(stall),
    .addr_err(addr_err), .bad_addr(bad_addr), .mem_address(mem_address),
    .mem_read(mem_read), .mem_write(mem_write), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (pre_en)         mem[pre_idx] <= pre_val;
    else if (mem_write) mem[mem_address[7:2]] <= mem_write_data;
  end

  always @(posedge clk) if (mem_write) seen_write <= 1'b1;

  function automatic logic ref_fault(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic u, input logic [31:0] a);
    logic [31:0] v;
    v = w >> ((a % 4) * 8);
    if (sz == 2'd0) return u ? (v & 32'hFF) : ((v & 32'h80) != 0 ? (v | 32'hFFFFFF00) : (v & 32'hFF));
    if (sz == 2'd1) return u ? (v & 32'hFFFF) : ((v & 32'h8000) != 0 ? (v | 32'hFFFF0000) : (v & 32'hFFFF));
    return w;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << ((a % 4) * 8);
    return (w & ~mask) | ((d << ((a % 4) * 8)) & mask);
  endfunction

  task automatic set_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
  endtask

  task automatic idle_req();
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    idle_req();
    pre_en = 1'b1; pre_idx = idx[5:0]; pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (stall !== 1'b0 || addr_err !== 1'b0 || bad_addr !== 32'h0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: stall=%b addr_err=%b bad_addr=%h rd=%b wr=%b required 0,0,0,0,0",
               stall, addr_err, bad_addr, mem_read, mem_write);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load_ext();
    logic [1:0]  sz [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
    logic [31:0] ex [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFFAABB, 32'h00008899};
    preload(4, 32'h8899AABB);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_req(1'b0, sz[i], un[i], ad[i], 32'h0);
      #1;
      checks++;
      if (load_data !== ex[i] || stall !== 1'b0 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
        errors++;
        $display("FAIL load_ext[%0d]: data=%h stall=%b rd=%b wr=%b required %h,0,1,0",
                 i, load_data, stall, mem_read, mem_write, ex[i]);
      end
    end
    @(negedge clk); idle_req(); #1;
    checks++;
    if (load_data !== 32'h0 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL idle_defaults: load_data=%h rd=%b required 0,0", load_data, mem_read);
    end
  endtask

  task automatic test_byte_store();
    @(negedge clk);
    set_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000CC);
    #1;
    checks++;
    if (stall !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h10) begin
      errors++;
      $display("FAIL sb_cycle0: stall=%b rd=%b wr=%b addr=%h required 1,1,0,00000010",
               stall, mem_read, mem_write, mem_address);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_write_data !== 32'h8899CCBB || stall !== 1'b0) begin
      errors++;
      $display("FAIL sb_cycle1: wr=%b rd=%b wdata=%h stall=%b required 1,0,8899ccbb,0",
               mem_write, mem_read, mem_write_data, stall);
    end
    @(negedge clk);
    set_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    #1;
    checks++;
    if (load_data !== 32'h8899CCBB) begin
      errors++;
      $display("FAIL sb_readback: got %h required 8899ccbb", load_data);
    end
  endtask

  task automatic test_word_store();
    @(negedge clk);
    set_req(1'b1, 2'd2, 1'b0, 32'h1C, 32'hABCDEF78);
    #1;
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || stall !== 1'b0 || mem_write_data !== 32'hABCDEF78) begin
      errors++;
      $display("FAIL sw: wr=%b rd=%b stall=%b wdata=%h required 1,0,0,abcdef78",
               mem_write, mem_read, stall, mem_write_data);
    end
    @(negedge clk);
    set_req(1'b0, 2'd2, 1'b0, 32'h1C, 32'h0);
    #1;
    checks++;
    if (load_data !== 32'hABCDEF78) begin
      errors++;
      $display("FAIL sw_readback: got %h required abcdef78", load_data);
    end
  endtask

  task automatic test_faults();
    logic        wr [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  sz [3] = '{2'd2, 2'd1, 2'd3};
    logic [31:0] ad [3] = '{32'h1E, 32'h1F, 32'h20};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_req(wr[i], sz[i], 1'b0, ad[i], 32'hDEADBEEF);
      #1;
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || stall !== 1'b0) begin
        errors++;
        $display("FAIL fault_block[%0d]: rd=%b wr=%b stall=%b required 0,0,0", i, mem_read, mem_write, stall);
      end
      @(negedge clk); idle_req();
      checks++;
      if (addr_err !== 1'b1 || bad_addr !== ad[i]) begin
        errors++;
        $display("FAIL fault_pulse[%0d]: addr_err=%b bad_addr=%h required 1,%h", i, addr_err, bad_addr, ad[i]);
      end
      @(negedge clk);
      checks++;
      if (addr_err !== 1'b0 || bad_addr !== ad[i]) begin
        errors++;
        $display("FAIL fault_end[%0d]: addr_err=%b bad_addr=%h required 0,%h", i, addr_err, bad_addr, ad[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] st;
    preload(4, 32'h8899AABB);
    @(negedge clk); set_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234); #1; st[3] = stall;
    @(negedge clk); #1; st[2] = stall;
    @(negedge clk); set_req(1'b1, 2'd0, 1'b0, 32'h10, 32'h00000056); #1; st[1] = stall;
    @(negedge clk); #1; st[0] = stall;
    @(negedge clk); idle_req();
    checks++;
    if (st !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_stall: pattern=%b required 1010", st);
    end
    checks++;
    if (mem[4] !== 32'h1234AA56) begin
      errors++;
      $display("FAIL b2b_word: got %h required 1234aa56", mem[4]);
    end
  endtask

  task automatic test_random();
    logic        w, u, f, exp_err;
    logic [1:0]  sz;
    logic [31:0] a, d, ea, exp_bad;
    exp_err = 1'b0;
    exp_bad = 32'h20;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      preload(i, ref_mem[i]);
    end
    for (int n = 0; n < 120; n++) begin
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 63);
      d  = $urandom;
      f  = ref_fault(sz, a);
      ea = a & 32'hFFFFFFFC;
      @(negedge clk);
      checks++;
      if (addr_err !== exp_err || bad_addr !== exp_bad) begin
        errors++;
        $display("FAIL rnd_err[%0d]: addr_err=%b bad_addr=%h required %b,%h", n, addr_err, bad_addr, exp_err, exp_bad);
      end
      set_req(w, sz, u, a, d);
      #1;
      checks++;
      if (f) begin
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || stall !== 1'b0) begin
          errors++;
          $display("FAIL rnd_fault[%0d]: rd=%b wr=%b stall=%b required 0,0,0", n, mem_read, mem_write, stall);
        end
      end else if (!w) begin
        if (load_data !== ref_load(ref_mem[a/4], sz, u, a) || stall !== 1'b0 || mem_write !== 1'b0) begin
          errors++;
          $display("FAIL rnd_load[%0d]: data=%h stall=%b wr=%b required %h,0,0",
                   n, load_data, stall, mem_write, ref_load(ref_mem[a/4], sz, u, a));
        end
      end else if (sz == 2'd2) begin
        if (mem_write !== 1'b1 || mem_write_data !== d || mem_address !== ea || stall !== 1'b0) begin
          errors++;
          $display("FAIL rnd_sw[%0d]: wr=%b wdata=%h addr=%h stall=%b required 1,%h,%h,0",
                   n, mem_write, mem_write_data, mem_address, stall, d, ea);
        end
        ref_mem[a/4] = d;
      end else begin
        if (stall !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== ea) begin
          errors++;
          $display("FAIL rnd_rmw0[%0d]: stall=%b rd=%b wr=%b addr=%h required 1,1,0,%h",
                   n, stall, mem_read, mem_write, mem_address, ea);
        end
        ref_mem[a/4] = ref_store(ref_mem[a/4], sz, a, d);
        @(negedge clk); #1;
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_write_data !== ref_mem[a/4] || stall !== 1'b0) begin
          errors++;
          $display("FAIL rnd_rmw1[%0d]: wr=%b rd=%b wdata=%h stall=%b required 1,0,%h,0",
                   n, mem_write, mem_read, mem_write_data, stall, ref_mem[a/4]);
        end
      end
      exp_err = f;
      if (f) exp_bad = a;
    end
    @(negedge clk); idle_req();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== ref_mem[i]) begin
        errors++;
        $display("FAIL rnd_final[%0d]: mem=%h required %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_reset_merge();
    preload(4, 32'h8899AABB);
    @(negedge clk);
    set_req(1'b1, 2'd0, 1'b0, 32'h10, 32'h00000077);
    seen_write = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || stall !== 1'b0 || addr_err !== 1'b0 || bad_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_merge_outputs: wr=%b stall=%b addr_err=%b bad_addr=%h required 0,0,0,0",
               mem_write, stall, addr_err, bad_addr);
    end
    @(negedge clk); idle_req();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem[4] !== 32'h8899AABB || seen_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_merge_mem: mem=%h wrote=%b required 8899aabb,0", mem[4], seen_write);
    end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_byte_store();
    test_word_store();
    test_faults();
    test_back_to_back();
    test_random();
    test_reset_merge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
